// File: rtl/wb_pkg.sv
// Shared writeback types: default widths/depth and the memory-result queue entry.
package wb_pkg;

   localparam int unsigned DefAddrWidth = 5;
   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefDepth     = 2;

   typedef struct packed {
      logic [DefAddrWidth-1:0] rd;
      logic [DefDataWidth-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Memory-result queue: DEPTH entries (power of two), pointers wrap naturally.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH   = DefDepth,
   parameter type         entry_t = wb_entry_t
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  entry_t                       wdata,
   output entry_t                       rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   entry_t          mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU first, then queued load results, plus load scoreboard.
// Optional WB_BYPASS_EN: a load arriving to an empty queue with no ALU write goes straight out.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH    = DefDataWidth,
   parameter int unsigned DEPTH         = DefDepth
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alu_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]      alu_rd_i,
   input  logic [DATA_WIDTH-1:0]         alu_data_i,
   input  logic                          mem_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]      mem_rd_i,
   input  logic [DATA_WIDTH-1:0]         mem_data_i,
   output logic                          mem_ready_o,
   input  logic                          issue_valid_i,
   input  logic [ADDRESS_WIDTH-1:0]      issue_rd_i,
   output logic [ADDRESS_WIDTH-1:0]      AD3_o,
   output logic                          WE3_o,
   output logic [DATA_WIDTH-1:0]         WD3_o,
   output logic [2**ADDRESS_WIDTH-1:0]   pending_o,
   output logic                          overflow_o
);

   localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    data;
   } entry_t;

   entry_t                     head, mem_entry, in_entry;
   logic                       fifo_full, fifo_empty;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       alu_wr, mem_in_ok, bypass, push, pop, mem_wr;

   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
   logic [DATA_WIDTH-1:0]    wd_q, wd_d;
   logic [NumRegs-1:0]       pending_q, pending_d;
   logic                     overflow_q, overflow_d;

   assign in_entry  = '{rd: mem_rd_i, data: mem_data_i};
   assign alu_wr    = alu_valid_i && (alu_rd_i != '0);
   assign mem_in_ok = mem_valid_i && (mem_rd_i != '0);
   assign mem_ready_o = !fifo_full;

`ifdef WB_BYPASS_EN
   assign bypass = mem_in_ok && fifo_empty && !alu_wr;
`else
   assign bypass = 1'b0;
`endif

   assign pop       = !alu_wr && !fifo_empty;
   assign push      = mem_in_ok && mem_ready_o && !bypass;
   assign mem_wr    = pop || bypass;
   assign mem_entry = pop ? head : in_entry;

   wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (in_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   always_comb begin
      we_d       = 1'b0;
      ad_d       = '0;
      wd_d       = '0;
      pending_d  = pending_q;
      overflow_d = overflow_q || (mem_valid_i && !mem_ready_o);
      if (alu_wr) begin
         we_d = 1'b1;
         ad_d = alu_rd_i;
         wd_d = alu_data_i;
      end else if (mem_wr) begin
         we_d = 1'b1;
         ad_d = mem_entry.rd;
         wd_d = mem_entry.data;
         pending_d[mem_entry.rd] = 1'b0;
      end
      // Applied after retire so a same-cycle reissue keeps the bit set.
      if (issue_valid_i && (issue_rd_i != '0)) pending_d[issue_rd_i] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         ad_q       <= '0;
         wd_q       <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         we_q       <= we_d;
         ad_q       <= ad_d;
         wd_q       <= wd_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign WE3_o      = we_q;
   assign AD3_o      = ad_q;
   assign WD3_o      = wd_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: vector table plus fill, reset and latency sequences.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid_i, mem_valid_i, issue_valid_i;
   logic [4:0]  alu_rd_i, mem_rd_i, issue_rd_i;
   logic [31:0] alu_data_i, mem_data_i;
   logic        mem_ready_o;
   logic [4:0]  AD3_o;
   logic        WE3_o;
   logic [31:0] WD3_o;
   logic [31:0] pending_o;
   logic        overflow_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   writeback_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid_i   (alu_valid_i),
      .alu_rd_i      (alu_rd_i),
      .alu_data_i    (alu_data_i),
      .mem_valid_i   (mem_valid_i),
      .mem_rd_i      (mem_rd_i),
      .mem_data_i    (mem_data_i),
      .mem_ready_o   (mem_ready_o),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .AD3_o         (AD3_o),
      .WE3_o         (WE3_o),
      .WD3_o         (WD3_o),
      .pending_o     (pending_o),
      .overflow_o    (overflow_o)
   );

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      logic        iv;
      logic [4:0]  ird;
      logic        e_we;
      logic [4:0]  e_ad;
      logic [31:0] e_wd;
      logic        e_rdy;
      logic [31:0] e_pend;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                        input logic iv, input logic [4:0] ird);
      alu_valid_i   = av;
      alu_rd_i      = ard;
      alu_data_i    = adat;
      mem_valid_i   = mv;
      mem_rd_i      = mrd;
      mem_data_i    = mdat;
      issue_valid_i = iv;
      issue_rd_i    = ird;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_write(input string name, input logic we, input logic [4:0] ad,
                            input logic [31:0] wd);
      chk({name, ".we"}, 64'(WE3_o), 64'(we));
      chk({name, ".ad"}, 64'(AD3_o), 64'(ad));
      chk({name, ".wd"}, 64'(WD3_o), 64'(wd));
   endtask

   initial begin
      // av ard adat         mv mrd mdat        iv ird | we ad wd           rdy pending
      vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,         0, 0, 1, 5, 32'hDEADBEEF, 1, 0};
      vecs[1] = '{0, 0, 0,            0, 0, 0,         0, 0, 0, 0, 0,            1, 0};
      vecs[2] = '{0, 0, 0,            0, 0, 0,         1, 7, 0, 0, 0,            1, 32'h80};
      vecs[3] = '{1, 3, 32'h33,       1, 7, 32'h77,    0, 0, 1, 3, 32'h33,       1, 32'h80};
      vecs[4] = '{0, 0, 0,            0, 0, 0,         0, 0, 1, 7, 32'h77,       1, 0};
      vecs[5] = '{0, 0, 0,            0, 0, 0,         1, 9, 0, 0, 0,            1, 32'h200};
      vecs[6] = '{1, 0, 32'h11,       1, 0, 32'h22,    0, 0, 0, 0, 0,            1, 32'h200};
      vecs[7] = '{1, 1, 32'hA1,       1, 9, 32'h99,    0, 0, 1, 1, 32'hA1,       1, 32'h200};
      vecs[8] = '{0, 0, 0,            0, 0, 0,         1, 9, 1, 9, 32'h99,       1, 32'h200};
      vecs[9] = '{0, 0, 0,            0, 0, 0,         0, 0, 0, 0, 0,            1, 32'h200};

      rst_n = 1'b0;
      idle();
      tick();
      tick();
      chk_write("reset", 0, 0, 0);
      chk("reset.ready", 64'(mem_ready_o), 64'd1);
      chk("reset.pending", 64'(pending_o), 64'd0);
      chk("reset.overflow", 64'(overflow_o), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat,
               vecs[i].iv, vecs[i].ird);
         tick();
         chk_write($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_ad, vecs[i].e_wd);
         chk($sformatf("vec%0d.ready", i), 64'(mem_ready_o), 64'(vecs[i].e_rdy));
         chk($sformatf("vec%0d.pending", i), 64'(pending_o), 64'(vecs[i].e_pend));
         chk($sformatf("vec%0d.overflow", i), 64'(overflow_o), 64'd0);
         if (i == 6) chk("x0.count", 64'(dut.u_fifo.count), 64'd0);
      end

      // Fill: ALU busy while three loads arrive into a two-entry queue.
      drive(0, 0, 0, 0, 0, 0, 1, 11); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 12); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 13); tick();
      drive(1, 20, 32'h2001, 1, 11, 32'hB1, 0, 0); tick();
      chk_write("fill1", 1, 20, 32'h2001);
      chk("fill1.ready", 64'(mem_ready_o), 64'd1);
      drive(1, 20, 32'h2002, 1, 12, 32'hB2, 0, 0); tick();
      chk_write("fill2", 1, 20, 32'h2002);
      chk("fill2.ready", 64'(mem_ready_o), 64'd0);
      chk("fill2.overflow", 64'(overflow_o), 64'd0);
      drive(1, 20, 32'h2003, 1, 13, 32'hB3, 0, 0); tick();
      chk_write("fill3", 1, 20, 32'h2003);
      chk("fill3.overflow", 64'(overflow_o), 64'd1);
      idle(); tick();
      chk_write("drain1", 1, 11, 32'hB1);
      chk("drain1.ready", 64'(mem_ready_o), 64'd1);
      tick();
      chk_write("drain2", 1, 12, 32'hB2);
      tick();
      chk_write("drain3", 0, 0, 0);
      chk("drain.pending", 64'(pending_o), 64'h0000_2200);
      chk("drain.overflow", 64'(overflow_o), 64'd1);

      // Reset with a full queue discards both entries.
      drive(1, 21, 32'h3001, 1, 14, 32'hC1, 0, 0); tick();
      drive(1, 21, 32'h3002, 1, 15, 32'hC2, 0, 0); tick();
      chk("prerst.count", 64'(dut.u_fifo.count), 64'd2);
      idle();
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      chk_write("rst", 0, 0, 0);
      chk("rst.count", 64'(dut.u_fifo.count), 64'd0);
      chk("rst.ready", 64'(mem_ready_o), 64'd1);
      chk("rst.pending", 64'(pending_o), 64'd0);
      chk("rst.overflow", 64'(overflow_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_write($sformatf("postrst%0d", i), 0, 0, 0);
      end

      // Lone load into an empty queue: latency 1 with bypass, 2 without.
      drive(0, 0, 0, 1, 6, 32'h66, 0, 0); tick();
      idle();
`ifdef WB_BYPASS_EN
      chk_write("lat.c1", 1, 6, 32'h66);
      tick();
      chk_write("lat.c2", 0, 0, 0);
`else
      chk_write("lat.c1", 0, 0, 0);
      tick();
      chk_write("lat.c2", 1, 6, 32'h66);
`endif
      tick();
      chk_write("lat.c3", 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
